i2s_adc_deserializer: RTL



---
 rtl/i2s_adc_deserializer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_adc_deserializer.sv
// I2S ADC capture: oversampled BCLK/LRCLK/SDATA -> stereo frames in a FWFT FIFO.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay).
module i2s_adc_deserializer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          sdata,
    output logic [2*SAMPLE_WIDTH-1:0]     out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          locked,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam int FW = 2 * SAMPLE_WIDTH;
    localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_WIDTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
    logic                   bclk_d;
    logic                   bclk_s, lr_s, sd_s, bit_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_d    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdata};
            bclk_d    <= bclk_s;
        end
    end

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign lr_s    = lr_sync[SYNC_STAGES-1];
    assign sd_s    = sd_sync[SYNC_STAGES-1];
    assign bit_evt = bclk_s & ~bclk_d;

    state_t                  state_q, state_d;
    logic                    lr_prev_q, lr_prev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] word_q, word_d, left_q, left_d;
    logic                    push_q, push_d;
    logic [FW-1:0]           push_data_q, push_data_d;
    logic                    lr_chg, start, take;
    logic [SAMPLE_WIDTH-1:0] bit_mask, word_tk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_SYNC;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            word_q      <= '0;
            left_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            left_q      <= left_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    // Words are built left-justified by placing each bit at its final position,
    // so short words come out zero-filled and bits past SAMPLE_WIDTH are dropped.
    assign bit_mask = {{(SAMPLE_WIDTH-1){1'b0}}, sd_s} << (CNT_LAST - cnt_q);
    assign word_tk  = word_q | bit_mask;
    assign lr_chg   = lr_s != lr_prev_q;

    always_comb begin
        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        left_d      = left_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        start       = 1'b0;
        take        = 1'b0;
        if (bit_evt) begin
            lr_prev_d = lr_s;
            case (state_q)
                WAIT_SYNC: begin
                    if (lr_chg && !lr_s) begin
                        state_d = LEFT;
                        start   = 1'b1;
                    end
                end
                LEFT: begin
                    if (lr_chg) begin
                        left_d  = word_q;
                        state_d = RIGHT;
                        start   = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end
                RIGHT: begin
                    if (lr_chg) begin
                        // A full word was already pushed when the count hit SAMPLE_WIDTH.
                        if (cnt_q != '0 && cnt_q < CNT_FULL) begin
                            push_d      = 1'b1;
                            push_data_d = {left_q, word_q};
                        end
                        state_d = LEFT;
                        start   = 1'b1;
                    end else begin
                        take = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            push_d      = 1'b1;
                            push_data_d = {left_q, word_tk};
                        end
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end
        if (take && cnt_q < CNT_FULL) begin
            word_d = word_tk;
            cnt_d  = cnt_q + CW'(1);
        end
        if (start) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
            word_d = {sd_s, {(SAMPLE_WIDTH-1){1'b0}}};
            cnt_d  = CW'(1);
`else
            word_d = '0;
            cnt_d  = '0;
`endif
        end
    end

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          do_pop, do_push, drop;

    assign do_pop  = out_valid & out_ready;
    assign do_push = push_q & ((level != LVL_FULL) | do_pop);
    assign drop    = push_q & ~do_push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            locked   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (!do_push && do_pop) level <= level - LW'(1);
            if (push_q) locked <= 1'b1;
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data_q;
    end

    assign out_valid  = level != '0;
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

endmodule
